// File: rtl/addn_seq_pkg.sv
// addn_seq shared types and helpers.
// Holds the FSM state enum and the k-counter sizing function.
package addn_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } addn_state_t;

    // Counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/addn_seq_add_chunk.sv
// add_chunk: combinational CHUNK-bit ripple adder.
// Ports: a, b, ci in; s, co (carry out), c_msb (carry into the MSB) out.
module add_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/addn_seq.sv
// addn_seq: multi-cycle add/sub, CHUNK bits per clock, valid/ready on both sides.
// Ports: clk, rst (async high); in_valid/in_ready, ina, inb, cin, sub;
// out_valid/out_ready, sum, cout, ovf. ADDN_SEQ_OVF_EN builds the ovf logic.
module addn_seq
    import addn_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ina,
    input  logic [WIDTH-1:0] inb,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = clog2_min1(NCHUNK);
    localparam int BW     = clog2_min1(WIDTH);
    localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

    addn_state_t state, nstate;

    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry;

    logic [BW-1:0]    base;
    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;
    logic [CHUNK-1:0] cs;
    logic             co;
    logic             accept;
    logic             last;

    assign accept = (state == IDLE) && in_valid;
    assign last   = (state == RUN) && (k == KLAST);

    // Bit offset of the active chunk; always below WIDTH.
    assign base = BW'(k) * BW'(CHUNK);
    assign ca   = a_q[base +: CHUNK];
    assign cb   = b_q[base +: CHUNK];

`ifdef ADDN_SEQ_OVF_EN
    logic c_msb;
    logic cmsb_q;
`else
    logic c_msb_unused;
`endif

    add_chunk #(
        .CHUNK(CHUNK)
    ) u_add (
        .a    (ca),
        .b    (cb),
        .ci   (carry),
        .s    (cs),
        .co   (co),
`ifdef ADDN_SEQ_OVF_EN
        .c_msb(c_msb)
`else
        .c_msb(c_msb_unused)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (in_valid)  nstate = RUN;
            RUN:     if (last)      nstate = DONE;
            DONE:    if (out_ready) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Subtraction is A + ~B + 1, so B is inverted once at accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k     <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
            carry <= 1'b0;
        end else if (accept) begin
            k     <= '0;
            a_q   <= ina;
            b_q   <= sub ? ~inb : inb;
            carry <= sub | cin;
        end else if (state == RUN) begin
            sum_q[base +: CHUNK] <= cs;
            carry <= co;
            k     <= last ? '0 : k + KW'(1);
        end
    end

    assign sum  = sum_q;
    assign cout = carry;

`ifdef ADDN_SEQ_OVF_EN
    // Carry into the word MSB, taken from the top chunk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       cmsb_q <= 1'b0;
        else if (last) cmsb_q <= c_msb;
    end

    assign ovf = cmsb_q ^ carry;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_addn_seq.sv
// Self-checking bench for addn_seq (WIDTH=16, CHUNK=4).
// Arithmetic model plus directed vectors with literal expectations.
module tb_addn_seq;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] ina = '0;
    logic [WIDTH-1:0] inb = '0;
    logic             cin = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    always #5 clk = ~clk;

    addn_seq #(
        .WIDTH(WIDTH),
        .CHUNK(CHUNK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ina      (ina),
        .inb      (inb),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    int nvec  = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from plain modular arithmetic.
    function automatic logic [WIDTH+1:0] calc(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic c,
                                              input logic s);
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   t;
        logic             v;
        bb = s ? ~b : b;
        t  = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(s ? 1'b1 : c);
        v  = 1'b0;
`ifdef ADDN_SEQ_OVF_EN
        v  = (a[WIDTH-1] == bb[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
`endif
        return {v, t};
    endfunction

    // Model: a pending result becomes visible NCHUNK edges after accept.
    bit               pend = 1'b0;
    int               rem  = 0;
    logic [WIDTH-1:0] m_sum;
    logic             m_cout;
    logic             m_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
            rem  <= 0;
        end else if (pend && rem == 0 && out_ready) begin
            pend <= 1'b0;
        end else if (pend && rem > 0) begin
            rem <= rem - 1;
        end else if (!pend && in_valid) begin
            pend <= 1'b1;
            rem  <= NCHUNK;
            {m_ovf, m_cout, m_sum} <= calc(ina, inb, cin, sub);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", 32'(in_ready), 32'(!pend));
            chk("out_valid", 32'(out_valid), 32'(pend && rem == 0));
            if (pend && rem == 0) begin
                chk("model_sum", 32'(sum), 32'(m_sum));
                chk("model_cout", 32'(cout), 32'(m_cout));
                chk("model_ovf", 32'(ovf), 32'(m_ovf));
            end
        end
    end

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
    endtask

    // Issue one op from IDLE, wait for its result, leave it in DONE.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic c, input logic s);
        int n;
        @(posedge clk);
        #1;
        ina      = a;
        inb      = b;
        cin      = c;
        sub      = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(n);
        chk("latency", 32'(n), 32'(NCHUNK + 1));
    endtask

    task automatic release_out();
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic expect_res(input string name, input logic [WIDTH-1:0] s,
                              input logic c, input logic v);
        chk({name, "_sum"}, 32'(sum), 32'(s));
        chk({name, "_cout"}, 32'(cout), 32'(c));
        chk({name, "_ovf"}, 32'(ovf), 32'(v));
    endtask

    logic exp_ovf1;

    initial begin
        int n;
`ifdef ADDN_SEQ_OVF_EN
        exp_ovf1 = 1'b1;
`else
        exp_ovf1 = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'h0);

        issue(16'h0003, 16'h0005, 1'b0, 1'b0);
        expect_res("add", 16'h0008, 1'b0, 1'b0);
        release_out();

        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        expect_res("ripple", 16'h0000, 1'b1, 1'b0);
        release_out();

        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        expect_res("sovf", 16'h8000, 1'b0, exp_ovf1);
        release_out();

        issue(16'h0005, 16'h0007, 1'b1, 1'b1);
        expect_res("sub_borrow", 16'hFFFE, 1'b0, 1'b0);
        release_out();

        issue(16'h0008, 16'h0003, 1'b0, 1'b1);
        expect_res("sub_ok", 16'h0005, 1'b1, 1'b0);
        release_out();

        // Backpressure with a new request waiting.
        issue(16'h1111, 16'h2222, 1'b1, 1'b0);
        expect_res("bp", 16'h3334, 1'b0, 1'b0);
        ina      = 16'h0001;
        inb      = 16'h0002;
        cin      = 1'b0;
        sub      = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold", 32'(sum), 32'h3334);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("bp_taken", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        wait_valid(n);
        chk("bp_latency", 32'(n), 32'(NCHUNK + 1));
        expect_res("bp2", 16'h0003, 1'b0, 1'b0);
        release_out();

        // Reset while a result is held.
        issue(16'h8001, 16'h8000, 1'b0, 1'b0);
        expect_res("pre_rst", 16'h0001, 1'b1, exp_ovf1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        expect_res("mid_rst", 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Abort at edge T+2 of an operation.
        @(posedge clk);
        #1;
        ina      = 16'h0F0F;
        inb      = 16'h0101;
        cin      = 1'b0;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        rst = 1'b1;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_valid", 32'(out_valid), 32'd0);
        end
        issue(16'h1234, 16'h4321, 1'b0, 1'b0);
        expect_res("fresh", 16'h5555, 1'b0, 1'b0);
        release_out();

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
